// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: funct3 branch codes,
// FSM state encoding and branch-comparator mode constants.
package branch_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;
    localparam logic [2:0] F3_RSV3 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Comparator mode encoding; must agree with the branch comparator's BrUn input.
    localparam logic COMPARE_UNSIGNED = 1'b1;
    localparam logic COMPARE_SIGNED   = 1'b0;

    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Unsigned compares (BLTU/BGEU) are exactly the codes with funct3[1] set.
    function automatic logic cmp_mode(input logic [2:0] funct3);
        return funct3[1] ? COMPARE_UNSIGNED : COMPARE_SIGNED;
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Branch handshake, comparator and redirect signals between the EX stage
// (master) and the branch controller (slave).
interface branch_ctrl_if #(
    parameter int DATA_SIZE = 32
) ();

    logic                 br_valid;
    logic                 br_ready;
    logic [2:0]           funct3;
    logic                 is_jump;
    logic [DATA_SIZE-1:0] target;
    logic                 BrUn;
    logic                 BrEq;
    logic                 BrLT;
    logic                 pc_sel;
    logic [DATA_SIZE-1:0] pc_target;
    logic                 flush;
    logic                 illegal;

    modport master (
        output br_valid, funct3, is_jump, target, BrEq, BrLT,
        input  br_ready, BrUn, pc_sel, pc_target, flush, illegal
    );

    modport slave (
        input  br_valid, funct3, is_jump, target, BrEq, BrLT,
        output br_ready, BrUn, pc_sel, pc_target, flush, illegal
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational taken decision for a presented branch/jump, plus a flag for
// reserved funct3 codes on conditional branches.
module branch_cond
    import branch_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       is_jump,
    input  logic       BrEq,
    input  logic       BrLT,
    output logic       taken,
    output logic       reserved
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        taken    = 1'b0;
        reserved = 1'b0;
        if (is_jump) begin
            taken = 1'b1;
        end else begin
            case (funct3)
                F3_BEQ:          taken = BrEq;
                F3_BNE:          taken = !BrEq;
                F3_BLT, F3_BLTU: taken = BrLT;
                F3_BGE, F3_BGEU: taken = !BrLT;
                default:         reserved = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump controller: accepts one resolved branch at a time, redirects the
// PC one cycle after a taken accept and holds flush for FLUSH_CYCLES cycles.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_ctrl_if.slave     bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
    logic [DATA_SIZE-1:0]   pc_target_q;
    logic                   illegal_q;
    logic [CNT_W-1:0]       br_cnt_q, taken_cnt_q;

    logic taken, reserved, accept;
    logic ready, pc_sel, flush;

    branch_cond u_cond (
        .funct3   (bus.funct3),
        .is_jump  (bus.is_jump),
        .BrEq     (bus.BrEq),
        .BrLT     (bus.BrLT),
        .taken    (taken),
        .reserved (reserved)
    );

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        ready   = 1'b0;
        accept  = 1'b0;
        pc_sel  = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                ready  = 1'b1;
                accept = bus.br_valid;
                if (accept && taken) state_d = REDIRECT;
            end
            REDIRECT: begin
                pc_sel = 1'b1;
                flush  = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                flush  = 1'b1;
                fcnt_d = fcnt_q - 1'b1;
                if (fcnt_q == FLUSH_CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            pc_target_q <= '0;
            illegal_q   <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            illegal_q <= accept && reserved;
            if (accept && taken) pc_target_q <= bus.target;
            // Clear wins over a same-cycle accept; counts saturate at all-ones.
            if (cnt_clr) begin
                br_cnt_q    <= '0;
                taken_cnt_q <= '0;
            end else if (accept) begin
                if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
                if (taken && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + 1'b1;
            end
        end
    end

    assign bus.br_ready  = ready;
    assign bus.BrUn      = cmp_mode(bus.funct3);
    assign bus.pc_sel    = pc_sel;
    assign bus.flush     = flush;
    assign bus.pc_target = pc_target_q;
    assign bus.illegal   = illegal_q;
    assign br_cnt        = br_cnt_q;
    assign taken_cnt     = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: two instances (default config and a
// FLUSH_CYCLES=1 / 4-bit-counter config) share stimulus, each with its own model.
module tb_branch_ctrl;

    localparam int FC_A = 2;
    localparam int CW_A = 16;
    localparam int FC_B = 1;
    localparam int CW_B = 4;

    typedef struct {
        int          rem;
        bit          first;
        bit          illegal;
        logic [31:0] pc_target;
        int          br_cnt;
        int          taken_cnt;
    } mstate_t;

    typedef struct {
        logic        ready;
        logic        pc_sel;
        logic        flush;
        logic        illegal;
        logic [31:0] pc_target;
        logic [31:0] br_cnt;
        logic [31:0] taken_cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [2:0]  funct3;
    logic        is_jump;
    logic [31:0] target;
    logic        BrEq;
    logic        BrLT;
    logic        cnt_clr;

    logic [CW_A-1:0] br_cnt_a, taken_cnt_a;
    logic [CW_B-1:0] br_cnt_b, taken_cnt_b;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    mstate_t ma, mb;
    exp_t    qa[$];
    exp_t    qb[$];

    branch_ctrl_if #(.DATA_SIZE(32)) bus_a ();
    branch_ctrl_if #(.DATA_SIZE(32)) bus_b ();

    assign bus_a.br_valid = br_valid;
    assign bus_a.funct3   = funct3;
    assign bus_a.is_jump  = is_jump;
    assign bus_a.target   = target;
    assign bus_a.BrEq     = BrEq;
    assign bus_a.BrLT     = BrLT;
    assign bus_b.br_valid = br_valid;
    assign bus_b.funct3   = funct3;
    assign bus_b.is_jump  = is_jump;
    assign bus_b.target   = target;
    assign bus_b.BrEq     = BrEq;
    assign bus_b.BrLT     = BrLT;

    branch_ctrl #(.DATA_SIZE(32), .FLUSH_CYCLES(FC_A), .CNT_W(CW_A)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a),
        .cnt_clr   (cnt_clr),
        .br_cnt    (br_cnt_a),
        .taken_cnt (taken_cnt_a)
    );

    branch_ctrl #(.DATA_SIZE(32), .FLUSH_CYCLES(FC_B), .CNT_W(CW_B)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b),
        .cnt_clr   (cnt_clr),
        .br_cnt    (br_cnt_b),
        .taken_cnt (taken_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 'rem' counts remaining busy cycles after a taken accept.
    function automatic mstate_t model_step(input mstate_t s, input int fc, input int cmax);
        mstate_t n;
        bit      acc;
        bit      tk;
        bit      resv;
        n         = s;
        n.first   = 1'b0;
        n.illegal = 1'b0;
        if (!rst_n) begin
            n.rem       = 0;
            n.pc_target = '0;
            n.br_cnt    = 0;
            n.taken_cnt = 0;
            return n;
        end
        acc  = br_valid && (s.rem == 0);
        tk   = 1'b0;
        resv = 1'b0;
        if (s.rem > 0) n.rem = s.rem - 1;
        if (is_jump) tk = 1'b1;
        else begin
            case (funct3)
                3'd0:       tk = BrEq;
                3'd1:       tk = !BrEq;
                3'd4, 3'd6: tk = BrLT;
                3'd5, 3'd7: tk = !BrLT;
                default:    resv = 1'b1;
            endcase
        end
        if (acc) begin
            n.illegal = resv;
            if (tk) begin
                n.rem       = fc;
                n.first     = 1'b1;
                n.pc_target = target;
            end
        end
        if (cnt_clr) begin
            n.br_cnt    = 0;
            n.taken_cnt = 0;
        end else if (acc) begin
            if (n.br_cnt < cmax) n.br_cnt = n.br_cnt + 1;
            if (tk && n.taken_cnt < cmax) n.taken_cnt = n.taken_cnt + 1;
        end
        return n;
    endfunction

    function automatic exp_t expected(input mstate_t s);
        exp_t e;
        e.ready     = (s.rem == 0);
        e.pc_sel    = s.first;
        e.flush     = (s.rem > 0);
        e.illegal   = s.illegal;
        e.pc_target = s.pc_target;
        e.br_cnt    = 32'(s.br_cnt);
        e.taken_cnt = 32'(s.taken_cnt);
        return e;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got.ready !== want.ready || got.pc_sel !== want.pc_sel ||
            got.flush !== want.flush || got.illegal !== want.illegal ||
            got.pc_target !== want.pc_target || got.br_cnt !== want.br_cnt ||
            got.taken_cnt !== want.taken_cnt) begin
            errors++;
            $display("FAIL %s cyc=%0d got rdy=%b sel=%b fl=%b ill=%b tgt=%h bc=%0d tc=%0d want rdy=%b sel=%b fl=%b ill=%b tgt=%h bc=%0d tc=%0d",
                     name, cycle, got.ready, got.pc_sel, got.flush, got.illegal, got.pc_target,
                     got.br_cnt, got.taken_cnt, want.ready, want.pc_sel, want.flush, want.illegal,
                     want.pc_target, want.br_cnt, want.taken_cnt);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %b want %b", name, cycle, got, want);
        end
    endtask

    // Advance one clock: update both models from the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        cycle++;
        ma = model_step(ma, FC_A, (1 << CW_A) - 1);
        mb = model_step(mb, FC_B, (1 << CW_B) - 1);
        qa.push_back(expected(ma));
        qb.push_back(expected(mb));
        #1;
    endtask

    task automatic set_in(input logic v, input logic [2:0] f3, input logic j,
                          input logic [31:0] tgt, input logic eq, input logic lt,
                          input logic clr);
        br_valid = v;
        funct3   = f3;
        is_jump  = j;
        target   = tgt;
        BrEq     = eq;
        BrLT     = lt;
        cnt_clr  = clr;
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compares every presented output cycle against the scoreboard.
    initial begin
        exp_t got;
        forever begin
            @(negedge clk);
            check_bit("brun_a", bus_a.BrUn, funct3[1]);
            check_bit("brun_b", bus_b.BrUn, funct3[1]);
            if (qa.size() > 0) begin
                got.ready     = bus_a.br_ready;
                got.pc_sel    = bus_a.pc_sel;
                got.flush     = bus_a.flush;
                got.illegal   = bus_a.illegal;
                got.pc_target = bus_a.pc_target;
                got.br_cnt    = {16'd0, br_cnt_a};
                got.taken_cnt = {16'd0, taken_cnt_a};
                check("dut_a", got, qa.pop_front());
            end
            if (qb.size() > 0) begin
                got.ready     = bus_b.br_ready;
                got.pc_sel    = bus_b.pc_sel;
                got.flush     = bus_b.flush;
                got.illegal   = bus_b.illegal;
                got.pc_target = bus_b.pc_target;
                got.br_cnt    = {28'd0, br_cnt_b};
                got.taken_cnt = {28'd0, taken_cnt_b};
                check("dut_b", got, qb.pop_front());
            end
        end
    end

    initial begin
        ma = '{rem: 0, first: 1'b0, illegal: 1'b0, pc_target: 32'h0, br_cnt: 0, taken_cnt: 0};
        mb = ma;
        rst_n = 1'b0;
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        idle(1);

        // Taken BEQ to 0x100, then idle through the flush window.
        set_in(1'b1, 3'b000, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
        tick();
        idle(4);

        // BLTU not taken: counts without redirect.
        set_in(1'b1, 3'b110, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 3'b110, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0);
        tick();
        idle(2);

        // Reserved funct3 pulses illegal; a jump with the same code does not.
        set_in(1'b1, 3'b010, 1'b0, 32'h0000_0ABC, 1'b1, 1'b0, 1'b0);
        tick();
        idle(2);
        set_in(1'b1, 3'b010, 1'b1, 32'h0000_0DEF, 1'b1, 1'b0, 1'b0);
        tick();
        idle(4);

        // br_valid held through REDIRECT/FLUSH after a taken BNE.
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 3'b001, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 3'b101, 1'b0, 32'h0000_0300, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        idle(2);

        // Reset in the middle of a redirect.
        set_in(1'b1, 3'b100, 1'b0, 32'h0000_0400, 1'b0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(3);

        // Saturate the narrow counters with back-to-back jumps, then clear
        // together with an accept.
        set_in(1'b1, 3'b000, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        idle(4);
        set_in(1'b1, 3'b000, 1'b1, 32'h0000_0600, 1'b0, 1'b0, 1'b1);
        tick();
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            set_in($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3) == 0, $urandom(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
            tick();
        end
        rst_n = 1'b1;
        idle(4);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 32, giving the operand/PC width.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held after a redirect; legal range 1..7.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the statistics counter width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 br_valid  input  1  branch/jump instruction present in EX.
REQ-007 br_ready  output  1  block can accept an instruction this cycle.
REQ-008 funct3  input  3  branch condition code of the presented instruction.
REQ-009 is_jump  input  1  JAL/JALR, unconditionally taken.
REQ-010 target  input  DATA_SIZE  computed branch/jump target.
REQ-011 BrUn  output  1  comparator mode to branch comparator: 1 unsigned, 0 signed.
REQ-012 BrEq  input  1  comparator result In1 == In2.
REQ-013 BrLT  input  1  comparator result In1 < In2, per BrUn.
REQ-014 pc_sel  output  1  1 = load PC from pc_target.
REQ-015 pc_target  output  DATA_SIZE  registered redirect address.
REQ-016 flush  output  1  kill younger instructions in IF/ID.
REQ-017 illegal  output  1  one-cycle pulse: accepted branch had reserved funct3.
REQ-018 cnt_clr  input  1  synchronous clear of statistics counters.
REQ-019 br_cnt, taken_cnt  output  CNT_W each  accepted-branch and taken-branch counts.

Function
REQ-020 BrUn SHALL be combinational: funct3[1], independent of state, so comparator results are valid in the accept cycle.
REQ-021 Accept SHALL occur on a rising edge where br_valid && br_ready.
REQ-022 Taken decision at accept: 000 BEQ=BrEq; 001 BNE=!BrEq; 100 BLT and 110 BLTU=BrLT; 101 BGE and 111 BGEU=!BrLT; 010/011 not taken with illegal pulsed the following cycle; is_jump=1 forces taken regardless of funct3, and illegal SHALL NOT pulse.
REQ-023 States SHALL be IDLE, REDIRECT, FLUSH; br_ready=1 only in IDLE.
REQ-024 IDLE: accept with taken -> REDIRECT, capture target into pc_target; accept not taken or no accept -> stay IDLE.
REQ-025 REDIRECT (exactly 1 cycle): pc_sel=1, flush=1; next -> FLUSH if FLUSH_CYCLES>1, else IDLE.
REQ-026 FLUSH: flush=1, pc_sel=0, held FLUSH_CYCLES-1 cycles by a down-counter, then -> IDLE.
REQ-027 Redirect latency SHALL be exactly 1 cycle after accept; total flush assertion SHALL be exactly FLUSH_CYCLES consecutive cycles.
REQ-028 pc_target SHALL hold its value outside REDIRECT; it changes only on a taken accept.
REQ-029 br_valid while br_ready=0 SHALL be ignored, not queued; upstream holds it.
REQ-030 br_cnt SHALL increment on every accept; taken_cnt on every taken accept; both saturate at all-ones.
REQ-031 cnt_clr SHALL zero both counters next cycle and has priority over a simultaneous increment (that branch is not counted).

Reset
REQ-032 While rst_n=0 at a rising edge: state=IDLE, flush counter=0, pc_sel=0, flush=0, illegal=0, pc_target=0, br_cnt=0, taken_cnt=0.
REQ-033 Reset asserted in REDIRECT or FLUSH SHALL abort the redirect; no pc_sel or flush in the cycle after reset.
REQ-034 br_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-035 A shared package SHALL hold funct3 branch codes, state encoding, and BrUn mode constants (COMPARE_UNSIGNED=1, COMPARE_SIGNED=0), matching the comparator.
REQ-036 The taken decision (REQ-022) SHALL be a combinational sub-module branch_cond; FSM, counters and registers stay in branch_ctrl.

Verification
REQ-037 BEQ, BrEq=1, target=0x0000_0100, FLUSH_CYCLES=2 -> cycle+1 pc_sel=1, pc_target=0x100, flush=1; cycle+2 flush=1, pc_sel=0; cycle+3 br_ready=1, flush=0.
REQ-038 BLTU funct3=110 -> BrUn=1 same cycle; BrLT=0 -> no pc_sel/flush, br_ready stays 1, br_cnt=1, taken_cnt=0.
REQ-039 funct3=010, BrEq=1 -> illegal pulses 1 cycle, not taken; is_jump=1 with funct3=010 -> taken, no illegal.
REQ-040 Taken branch then br_valid held high during REDIRECT/FLUSH -> second branch accepted only in first IDLE cycle; br_cnt=2.
REQ-041 rst_n=0 during REDIRECT -> next cycle pc_sel=0, flush=0, counters 0, br_ready=1 after release.
REQ-042 Preload counters to 0xFFFF, taken accept -> both remain 0xFFFF; cnt_clr with a simultaneous accept -> both 0x0000.
